seq_div8: RTL

Iterative 16÷8 unsigned restoring divider: the inverse of the datapath's 8×8 → 16 unsigned multiplier. Accepts a 16-bit dividend and 8-bit divisor on a start/done handshake and produces an 8-bit quotient and 8-bit remainder after 8 iteration cycles. Divide-by-zero and quotient overflow are detected up front and answered in one cycle. Sits alongside the multiplier in the arithmetic unit for operand recovery and scaling.

---
 rtl/seq_div8.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/seq_div8.sv
// seq_div8: iterative 16/8 unsigned restoring divider.
// A start in IDLE either answers immediately (divide-by-zero or quotient
// overflow) or loads the operands and runs eight restoring steps, one per
// clock, retiring the quotient MSB first. Results and flags are held between
// done pulses.
module seq_div8 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic [7:0]  quotient,
  output logic [7:0]  remainder,
  output logic        busy,
  output logic        done,
  output logic        dbz,
  output logic        ovf
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  // Iteration counter: 0..7 while running, 8 after the last step.
  logic [3:0]  r_cnt;

  // Datapath: partial remainder, dividend/quotient shift register, divisor.
  // The partial remainder is always < divisor, so 8 bits hold it; the ninth
  // bit of the trial value only exists transiently in w_trial.
  logic [7:0]  r_part;
  logic [7:0]  r_qsh;
  logic [7:0]  r_dsr;

  // Held result registers.
  logic [7:0]  r_quo;
  logic [7:0]  r_rem;
  logic        r_done;
  logic        r_dbz;
  logic        r_ovf;

  // Control decodes for the current cycle.
  logic        w_accept;
  logic        w_err_dbz;
  logic        w_err_ovf;
  logic        w_finish;

  // One restoring step.
  logic [8:0]  w_trial;
  logic [7:0]  w_part_nxt;
  logic        w_qbit;

  // One restoring step: returns {quotient_bit, new_remainder}. When the trial
  // value is at least the divisor the difference is below the divisor, so the
  // low 8 bits of the subtraction are the exact new remainder.
  function automatic logic [8:0] f_restore_step(input logic [8:0] t,
                                                input logic [7:0] d);
    if (t >= {1'b0, d})
      return {1'b1, t[7:0] - d};
    else
      return {1'b0, t[7:0]};
  endfunction

  // Trial value: partial remainder shifted left with the next dividend bit.
  assign w_trial              = {r_part, r_qsh[7]};
  assign {w_qbit, w_part_nxt} = f_restore_step(w_trial, r_dsr);

  // Next-state and control decode; error cases never leave IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_err_dbz   = 1'b0;
    w_err_ovf   = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (divisor == 8'd0) begin
            w_err_dbz = 1'b1;
          end else if (dividend[15:8] >= divisor) begin
            // Upper half already >= divisor: quotient needs more than 8 bits.
            w_err_ovf = 1'b1;
          end else begin
            w_accept    = 1'b1;
            w_state_nxt = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (r_cnt == 4'd7) begin
          w_finish    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  // State register; reset aborts any division in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Iteration counter: cleared on accept, counts every RUN edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_cnt <= 4'd0;
    else if (w_accept)          r_cnt <= 4'd0;
    else if (r_state == ST_RUN) r_cnt <= r_cnt + 4'd1;
  end

  // Datapath registers: load operands on accept, shift one step per RUN edge.
  // Quotient bits enter at the LSB as dividend bits leave at the MSB.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_part <= dividend[15:8];
      r_qsh  <= dividend[7:0];
      r_dsr  <= divisor;
    end else if (r_state == ST_RUN) begin
      r_part <= w_part_nxt;
      r_qsh  <= {r_qsh[6:0], w_qbit};
    end
  end

  // Result registers: updated only when a done is being issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done <= 1'b0;
      r_quo  <= 8'd0;
      r_rem  <= 8'd0;
      r_dbz  <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_done <= w_err_dbz | w_err_ovf | w_finish;
      if (w_err_dbz | w_err_ovf) begin
        r_quo <= 8'hFF;
        r_rem <= dividend[7:0];
        r_dbz <= w_err_dbz;
        r_ovf <= w_err_ovf;
      end else if (w_finish) begin
        r_quo <= {r_qsh[6:0], w_qbit};
        r_rem <= w_part_nxt;
        r_dbz <= 1'b0;
        r_ovf <= 1'b0;
      end
    end
  end

  assign busy      = (r_state == ST_RUN);
  assign done      = r_done;
  assign quotient  = r_quo;
  assign remainder = r_rem;
  assign dbz       = r_dbz;
  assign ovf       = r_ovf;

endmodule
